// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings, arbiter state type and burst-length helper used by
// the arbiter, its interface and the bench.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2,
    ST_LOCK  = 2'd3
  } arb_state_t;

  // SINGLE and undefined-length INCR both count as one protected beat.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst[2:1])
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      2'b11:   return 5'd16;
      default: return 5'd1;
    endcase
  endfunction

  function automatic logic is_fixed_burst(input logic [2:0] hburst);
    return hburst[2:1] != 2'b00;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing bus signals; slave = arbiter side, master = environment side.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 3
);
  import ahb_pkg::*;

  // A transfer (address phase) is accepted on a rising hclk edge with
  // hready=1; with hready=0 every arbiter register holds its value.
  logic [NUM_MASTERS-1:0] hbusreq;
  logic [NUM_MASTERS-1:0] hlock;
  logic [1:0]             htrans;
  logic [2:0]             hburst;
  logic                   hready;
  logic [NUM_MASTERS-1:0] hgrant;
  logic [1:0]             hmaster;
  logic [1:0]             hmaster_d;
  logic                   hmastlock;
  arb_state_t             state;
  logic [4:0]             beat_cnt;

  modport slave (
    input  hbusreq, hlock, htrans, hburst, hready,
    output hgrant, hmaster, hmaster_d, hmastlock, state, beat_cnt
  );

  modport master (
    output hbusreq, hlock, htrans, hburst, hready,
    input  hgrant, hmaster, hmaster_d, hmastlock, state, beat_cnt
  );

endinterface

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', with
// 'last' itself searched at the very end.
module rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [1:0]   pick,
  output logic         valid
);

  int         cand;
  logic [1:0] cand_idx;

  always_comb begin
    pick     = last;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N; i++) begin
      cand     = (int'(last) + i) % N;
      cand_idx = 2'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        pick  = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with fixed-burst and locked-sequence protection.
// Drives one-hot grant plus address- and data-phase owner indices.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0
) (
  input logic          hclk,
  input logic          hresetn,
  ahb_arbiter_if.slave bus
);

  localparam logic [NUM_MASTERS-1:0] ONE       = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = ONE << DEFAULT_MASTER;
  localparam logic [1:0]             DEF_IDX   = 2'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] hgrant_q, grant_next;
  logic [1:0]             hmaster_q, hmaster_d_q;
  logic                   hmastlock_q;
  logic [4:0]             beat_cnt_q, beat_next;
  arb_state_t             state_q, state_next;

  logic [1:0] grant_idx;
  logic [1:0] pick_idx;
  logic       pick_valid;
  logic       is_nonseq, is_seq, fixed_nonseq;
  logic       lock_hold, arb_ok;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant_q[i]) grant_idx = 2'(i);
    end
  end

  assign is_nonseq    = (bus.htrans == HTRANS_NONSEQ);
  assign is_seq       = (bus.htrans == HTRANS_SEQ);
  assign fixed_nonseq = is_nonseq && is_fixed_burst(bus.hburst);
  assign lock_hold    = bus.hlock[hmaster_q] | hmastlock_q;

  // Handover is allowed in the address phase of a burst's last beat, so the
  // next owner gets its grant while that beat completes.
  assign arb_ok = bus.hready && !lock_hold && !fixed_nonseq &&
                  ((beat_cnt_q == 5'd0) || ((beat_cnt_q == 5'd1) && is_seq));

  // Rotation is anchored on the most recent grant so that continuous
  // requesters are served strictly in turn, one transfer each.
  rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (bus.hbusreq),
    .last  (grant_idx),
    .pick  (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    grant_next = hgrant_q;
    beat_next  = beat_cnt_q;
    state_next = state_q;
    if (arb_ok) begin
      grant_next = pick_valid ? (ONE << pick_idx) : DEF_GRANT;
    end
    if (bus.hready) begin
      if (is_nonseq) begin
        beat_next = fixed_nonseq ? (burst_len(bus.hburst) - 5'd1) : 5'd0;
      end else if (is_seq && (beat_cnt_q != 5'd0)) begin
        beat_next = beat_cnt_q - 5'd1;
      end
      if (lock_hold) begin
        state_next = ST_LOCK;
      end else if (beat_next != 5'd0) begin
        state_next = ST_BURST;
      end else if (arb_ok) begin
        state_next = pick_valid ? ST_OWN : ST_PARK;
      end else if (state_q == ST_BURST) begin
        state_next = ST_OWN;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      hgrant_q    <= DEF_GRANT;
      hmaster_q   <= DEF_IDX;
      hmaster_d_q <= DEF_IDX;
      hmastlock_q <= 1'b0;
      beat_cnt_q  <= 5'd0;
      state_q     <= ST_PARK;
    end else begin
      hgrant_q   <= grant_next;
      beat_cnt_q <= beat_next;
      state_q    <= state_next;
      if (bus.hready) begin
        hmaster_q   <= grant_idx;
        hmaster_d_q <= hmaster_q;
        hmastlock_q <= bus.hlock[grant_idx];
      end
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmaster_d = hmaster_d_q;
  assign bus.hmastlock = hmastlock_q;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter (3 masters, default master 0) with an
// expected-value queue of {hgrant, hmaster, hmaster_d, hmastlock}.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] exp;

  ahb_arbiter_if #(.NUM_MASTERS(3)) bus ();

  ahb_arbiter #(.NUM_MASTERS(3), .DEFAULT_MASTER(0)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  // Clock and grant sanity monitor.
  always #5 hclk = ~hclk;

  always @(negedge hclk) begin
    if (mon_en && hresetn === 1'b1) begin
      checks++;
      if (!$onehot(bus.hgrant)) begin
        errors++;
        $display("FAIL onehot hgrant got=%b", bus.hgrant);
      end
    end
  end

  function automatic logic [7:0] snap();
    return {bus.hgrant, bus.hmaster, bus.hmaster_d, bus.hmastlock};
  endfunction

  function automatic logic [7:0] pack(input logic [2:0] g, input logic [1:0] m,
                                      input logic [1:0] md, input logic l);
    return {g, m, md, l};
  endfunction

  // Driver tasks.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [2:0] req, input logic [2:0] lock,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    bus.hbusreq = req;
    bus.hlock   = lock;
    bus.htrans  = tr;
    bus.hburst  = bu;
    bus.hready  = rdy;
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    drive(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    step();
    step();
    hresetn = 1'b1;
  endtask

  // Reset, then give master m the bus with idle transfers for two cycles.
  task automatic take_bus(input int m);
    logic [2:0] r;
    r = 3'b001 << m;
    do_reset();
    drive(r, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    step();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    mon_en = 1'b1;
    exp_q.push_back(pack(3'b001, 2'd0, 2'd0, 1'b0));
    exp = exp_q.pop_front();
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b", snap(), exp);
    end
    checks++;
    if (bus.state !== ST_PARK || bus.beat_cnt !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got=%0d/%0d exp=%0d/0", bus.state, bus.beat_cnt, ST_PARK);
    end
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(pack(3'b001, 2'd0, 2'd0, 1'b0));
      step();
      exp = exp_q.pop_front();
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL park[%0d] got=%b exp=%b", i, snap(), exp);
      end
    end
    checks++;
    if (bus.state !== ST_PARK) begin
      errors++;
      $display("FAIL park_state got=%0d exp=%0d", bus.state, ST_PARK);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    drive(3'b110, 3'b000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
    exp_q.push_back(pack(3'b010, 2'd0, 2'd0, 1'b0));
    exp_q.push_back(pack(3'b100, 2'd1, 2'd0, 1'b0));
    exp_q.push_back(pack(3'b010, 2'd2, 2'd1, 1'b0));
    exp_q.push_back(pack(3'b100, 2'd1, 2'd2, 1'b0));
    for (int i = 0; i < 4; i++) begin
      step();
      exp = exp_q.pop_front();
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL rotation[%0d] got=%b exp=%b", i, snap(), exp);
      end
    end
    checks++;
    if (bus.state !== ST_OWN) begin
      errors++;
      $display("FAIL rotation_state got=%0d exp=%0d", bus.state, ST_OWN);
    end
  endtask

  task automatic test_burst(input bit stall);
    logic [1:0] tr[6];
    logic       rd[6];
    logic [4:0] cn[6];
    logic [2:0] gr[6];
    logic [2:0] hb;
    int         n;
    hb = 3'($urandom_range(2, 3));
    take_bus(1);
    checks++;
    if (bus.hmaster !== 2'd1 || bus.hgrant !== 3'b010) begin
      errors++;
      $display("FAIL burst_setup got=%0d/%b exp=1/010", bus.hmaster, bus.hgrant);
    end
    if (stall) begin
      n  = 6;
      tr = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ};
      rd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      cn = '{5'd3, 5'd2, 5'd2, 5'd2, 5'd1, 5'd0};
      gr = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    end else begin
      n  = 4;
      tr = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
      rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      cn = '{5'd3, 5'd2, 5'd1, 5'd0, 5'd0, 5'd0};
      gr = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100};
    end
    for (int i = 0; i < n; i++) begin
      drive(3'b111, 3'b000, tr[i], hb, rd[i]);
      exp_q.push_back(pack(gr[i], 2'd1, 2'd1, 1'b0));
      step();
      exp = exp_q.pop_front();
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL burst%0d[%0d] got=%b exp=%b", stall, i, snap(), exp);
      end
      checks++;
      if (bus.beat_cnt !== cn[i]) begin
        errors++;
        $display("FAIL burst%0d_cnt[%0d] got=%0d exp=%0d", stall, i, bus.beat_cnt, cn[i]);
      end
    end
    checks++;
    if (bus.state !== ST_OWN) begin
      errors++;
      $display("FAIL burst%0d_state got=%0d exp=%0d", stall, bus.state, ST_OWN);
    end
    drive(3'b111, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    exp_q.push_back(pack(3'b001, 2'd2, 2'd1, 1'b0));
    step();
    exp = exp_q.pop_front();
    checks++;
    if (snap() !== exp) begin
      errors++;
      $display("FAIL burst%0d_handover got=%b exp=%b", stall, snap(), exp);
    end
  endtask

  task automatic test_incr();
    take_bus(1);
    drive(3'b111, 3'b000, HTRANS_NONSEQ, HBURST_INCR, 1'b1);
    exp_q.push_back(pack(3'b100, 2'd1, 2'd1, 1'b0));
    step();
    drive(3'b111, 3'b000, HTRANS_SEQ, HBURST_INCR, 1'b1);
    exp_q.push_back(pack(3'b001, 2'd2, 2'd1, 1'b0));
    step();
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      checks++;
      if (i == 1 && snap() !== exp) begin
        errors++;
        $display("FAIL incr[%0d] got=%b exp=%b", i, snap(), exp);
      end else if (i == 0 && bus.beat_cnt !== 5'd0) begin
        errors++;
        $display("FAIL incr_cnt got=%0d exp=0", bus.beat_cnt);
      end
    end
  endtask

  task automatic test_lock();
    logic [2:0] lk;
    do_reset();
    exp_q.push_back(pack(3'b001, 2'd0, 2'd0, 1'b1));
    exp_q.push_back(pack(3'b001, 2'd0, 2'd0, 1'b1));
    exp_q.push_back(pack(3'b001, 2'd0, 2'd0, 1'b1));
    exp_q.push_back(pack(3'b001, 2'd0, 2'd0, 1'b0));
    exp_q.push_back(pack(3'b010, 2'd0, 2'd0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      lk = (i < 3) ? 3'b001 : 3'b000;
      drive(3'b111, lk, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      step();
      exp = exp_q.pop_front();
      checks++;
      if (snap() !== exp) begin
        errors++;
        $display("FAIL lock[%0d] got=%b exp=%b", i, snap(), exp);
      end
      if (i == 2) begin
        checks++;
        if (bus.state !== ST_LOCK) begin
          errors++;
          $display("FAIL lock_state got=%0d exp=%0d", bus.state, ST_LOCK);
        end
      end
    end
    checks++;
    if (bus.state !== ST_OWN) begin
      errors++;
      $display("FAIL unlock_state got=%0d exp=%0d", bus.state, ST_OWN);
    end
  endtask

  task automatic test_reset_mid_burst();
    take_bus(2);
    drive(3'b100, 3'b000, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
    step();
    drive(3'b100, 3'b000, HTRANS_SEQ, HBURST_INCR8, 1'b1);
    step();
    step();
    exp_q.push_back(pack(3'b100, 2'd2, 2'd2, 1'b0));
    exp = exp_q.pop_front();
    checks++;
    if (snap() !== exp || bus.beat_cnt !== 5'd5 || bus.state !== ST_BURST) begin
      errors++;
      $display("FAIL midburst got=%b cnt=%0d st=%0d exp=%b cnt=5 st=%0d",
               snap(), bus.beat_cnt, bus.state, exp, ST_BURST);
    end
    hresetn = 1'b0;
    exp_q.push_back(pack(3'b001, 2'd0, 2'd0, 1'b0));
    step();
    exp = exp_q.pop_front();
    checks++;
    if (snap() !== exp || bus.beat_cnt !== 5'd0 || bus.state !== ST_PARK) begin
      errors++;
      $display("FAIL midburst_reset got=%b cnt=%0d st=%0d exp=%b cnt=0 st=%0d",
               snap(), bus.beat_cnt, bus.state, exp, ST_PARK);
    end
    hresetn = 1'b1;
  endtask

  initial begin
    drive(3'b000, 3'b000, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
    test_reset();
    test_rotation();
    test_burst(1'b0);
    test_burst(1'b1);
    test_incr();
    test_lock();
    test_reset_mid_burst();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
